// File: rtl/logic_op_scheduler_if.sv
// Request/response bundle for logic_op_scheduler.
//   master: requester/consumer side (drives req_valid/op/a/b and rsp_ready)
//   slave : scheduler side (drives req_ready and rsp_valid/data/id)
// Requester i owns bit i of req_valid/req_ready, bits [2i+1:2i] of req_op
// and slice i (WIDTH bits) of req_a/req_b.
interface logic_op_scheduler_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/logic_op_scheduler.sv
// Shares one bitwise logic unit (AND/OR/XOR/NOT b) between NREQ requesters.
// One request is granted at a time, executed, and returned on a single
// response port tagged with the requester index.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - logic_op_scheduler_if.slave: per-requester valid/ready/op/a/b,
//          response valid/ready/data/id
//   busy - high whenever the scheduler is not idle
//
// Build option: define LOGIC_SCHED_FIXED_PRIO_EN for fixed priority (lowest
// asserted index wins, no rotating pointer). Default is round-robin.
module logic_op_scheduler #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_op_scheduler_if.slave  bus,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [IDW:0] NReqW = (IDW+1)'(NREQ);

  state_e           state_q, state_d;
  logic [IDW-1:0]   win_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] data_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] result;

  logic [IDW-1:0]   scan_base;
  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  logic             accept;

  logic [1:0]       op_arr [NREQ];
  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];

  // Unpack the flat per-requester buses so the winner can be muxed by index.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g] = bus.req_op[2*g +: 2];
    assign a_arr[g]  = bus.req_a[WIDTH*g +: WIDTH];
    assign b_arr[g]  = bus.req_b[WIDTH*g +: WIDTH];
  end

  // Scan upward from scan_base with wrap; the first valid index wins.
  always_comb begin
    logic [IDW:0] sum;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, scan_base} + (IDW+1)'(k);
      if (sum >= NReqW) sum = sum - NReqW;
      if (!grant_any && bus.req_valid[sum[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[IDW-1:0];
      end
    end
  end

  assign accept = (state_q == StIdle) && grant_any;

`ifdef LOGIC_SCHED_FIXED_PRIO_EN
  assign scan_base = '0;
`else
  logic [IDW-1:0] ptr_q;

  // Pointer moves past the winner on each grant only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  assign scan_base = ptr_q;
`endif

  // FSM next state and grant output.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          bus.req_ready[grant_idx] = 1'b1;
          state_d                  = StExec;
        end
      end
      StExec:  state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Shared logic unit.
  always_comb begin
    result = '0;
    unique case (op_q)
      2'b00: result = a_q & b_q;
      2'b01: result = a_q | b_q;
      2'b10: result = a_q ^ b_q;
      2'b11: result = ~b_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      win_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        win_q <= grant_idx;
        op_q  <= op_arr[grant_idx];
        a_q   <= a_arr[grant_idx];
        b_q   <= b_arr[grant_idx];
      end
      if (state_q == StExec) begin
        data_q <= result;
        id_q   <= win_q;
      end
    end
  end

  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Self-checking bench for logic_op_scheduler (NREQ=4, WIDTH=8): directed
// scenarios plus randomized traffic checked every cycle against a
// transaction-level reference model.
module tb_logic_op_scheduler;

  localparam int NREQ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [3:0] valid_v;
  logic [1:0] op_v [NREQ];
  logic [7:0] a_v  [NREQ];
  logic [7:0] b_v  [NREQ];
  logic       rsp_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  logic_op_scheduler_if #(.NREQ(4), .WIDTH(8)) bus ();

  assign bus.req_valid = valid_v;
  assign bus.req_op    = {op_v[3], op_v[2], op_v[1], op_v[0]};
  assign bus.req_a     = {a_v[3], a_v[2], a_v[1], a_v[0]};
  assign bus.req_b     = {b_v[3], b_v[2], b_v[1], b_v[0]};
  assign bus.rsp_ready = rsp_rdy;

  logic_op_scheduler #(.NREQ(4), .WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lop(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~b;
    endcase
  endfunction

  // Reference model: at most one transaction in flight; the response shows
  // two cycles after acceptance and stays until the consumer takes it.
  int         m_ptr = 0;
  bit         m_fl  = 1'b0;
  int         m_age = 0;
  int         m_id  = 0;
  logic [7:0] m_res = '0;
  bit         after_rst = 1'b0;
  int         cyc = 0;
  logic [3:0] gnt_seen = '0;
  int         grant_log [$];
  int         grant_cyc [$];

  always @(negedge clk) begin : model
    int         w;
    logic [3:0] exp_rdy;
    if (rst) begin
      m_ptr     = 0;
      m_fl      = 1'b0;
      gnt_seen  = '0;
      after_rst = 1'b1;
    end else begin
      cyc++;
      exp_rdy = '0;
      if (after_rst) begin
        check_eq("m_rst_data", bus.rsp_data, 0);
        check_eq("m_rst_id", bus.rsp_id, 0);
        after_rst = 1'b0;
      end
      check_eq("m_busy", busy, m_fl);
      if (!m_fl) begin
        check_eq("m_idle_valid", bus.rsp_valid, 0);
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (w < 0 && valid_v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        if (w >= 0) begin
          exp_rdy[w] = 1'b1;
          m_fl  = 1'b1;
          m_age = 0;
          m_id  = w;
          m_res = lop(op_v[w], a_v[w], b_v[w]);
`ifndef LOGIC_SCHED_FIXED_PRIO_EN
          m_ptr = (w + 1) % NREQ;
`endif
          grant_log.push_back(w);
          grant_cyc.push_back(cyc);
        end
      end else begin
        m_age++;
        check_eq("m_rsp_valid", bus.rsp_valid, (m_age >= 2) ? 1 : 0);
        if (m_age >= 2) begin
          check_eq("m_rsp_data", bus.rsp_data, m_res);
          check_eq("m_rsp_id", bus.rsp_id, m_id);
          if (rsp_rdy) m_fl = 1'b0;
        end
      end
      check_eq("m_req_ready", bus.req_ready, exp_rdy);
      gnt_seen = bus.req_ready;
    end
  end

  task automatic new_req(input int i);
    valid_v[i] = 1'b1;
    op_v[i]    = 2'($urandom_range(3));
    a_v[i]     = 8'($urandom);
    b_v[i]     = 8'($urandom);
  endtask

  // One cycle of traffic: granted requesters either re-request or drop,
  // idle requesters raise a new request with probability p_valid percent.
  task automatic drive_step(input bit refill, input int p_valid, input int rdy_pct);
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_seen[i]) begin
        if (refill) new_req(i);
        else valid_v[i] = 1'b0;
      end else if (!valid_v[i] && $urandom_range(99) < p_valid) begin
        new_req(i);
      end
    end
    rsp_rdy = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic idle_cycles(input int n);
    valid_v = '0;
    rsp_rdy = 1'b1;
    repeat (n) drive_step(1'b0, 0, 100);
  endtask

  task automatic run_one(input string tag, input int i, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_d);
    @(posedge clk); #1;
    rsp_rdy    = 1'b1;
    valid_v    = '0;
    valid_v[i] = 1'b1;
    op_v[i]    = op;
    a_v[i]     = a;
    b_v[i]     = b;
    @(negedge clk);
    check_eq({tag, "_ready"}, bus.req_ready, 32'(4'b0001 << i));
    @(posedge clk); #1;
    valid_v[i] = 1'b0;
    @(negedge clk);
    check_eq({tag, "_t1_valid"}, bus.rsp_valid, 0);
    @(negedge clk);
    check_eq({tag, "_t2_valid"}, bus.rsp_valid, 1);
    check_eq({tag, "_data"}, bus.rsp_data, exp_d);
    check_eq({tag, "_id"}, bus.rsp_id, i);
  endtask

  initial begin
    int exp_id;
    rst     = 1'b1;
    valid_v = '0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op_v[i] = '0;
      a_v[i]  = '0;
      b_v[i]  = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_rsp_data", bus.rsp_data, 0);
    check_eq("rst_rsp_id", bus.rsp_id, 0);
    check_eq("rst_busy", busy, 0);

    // All requesters valid continuously from reset.
    grant_log.delete();
    grant_cyc.delete();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) new_req(i);
    repeat (17) drive_step(1'b1, 0, 100);
    valid_v = '0;
    check_eq("rr_count_ge6", (grant_log.size() >= 6) ? 1 : 0, 1);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
`ifdef LOGIC_SCHED_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = k % NREQ;
`endif
      check_eq("rr_id", grant_log[k], exp_id);
      if (k > 0) check_eq("rr_gap", grant_cyc[k] - grant_cyc[k-1], 3);
    end
    idle_cycles(4);

    run_one("single", 2, 2'b00, 8'hF0, 8'h3C, 8'h30);
    run_one("op_and", 0, 2'b00, 8'hAA, 8'h0F, 8'h0A);
    run_one("op_or",  0, 2'b01, 8'hAA, 8'h0F, 8'hAF);
    run_one("op_xor", 0, 2'b10, 8'hAA, 8'h0F, 8'hA5);
    run_one("op_not", 0, 2'b11, 8'hAA, 8'h0F, 8'hF0);
    run_one("skip_g1", 1, 2'b00, 8'hFF, 8'h0F, 8'h0F);
    run_one("skip_g0", 0, 2'b01, 8'h11, 8'h22, 8'h33);

    // Backpressure: response held for 10 cycles while req 0 waits.
    @(posedge clk); #1;
    valid_v    = '0;
    valid_v[3] = 1'b1;
    op_v[3]    = 2'b10;
    a_v[3]     = 8'h5A;
    b_v[3]     = 8'hFF;
    rsp_rdy    = 1'b0;
    @(posedge clk); #1;
    valid_v[3] = 1'b0;
    valid_v[0] = 1'b1;
    op_v[0]    = 2'b11;
    a_v[0]     = 8'h00;
    b_v[0]     = 8'h3C;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("bp_valid", bus.rsp_valid, 1);
      check_eq("bp_data", bus.rsp_data, 8'hA5);
      check_eq("bp_id", bus.rsp_id, 3);
      check_eq("bp_req_ready", bus.req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    check_eq("bp_take_valid", bus.rsp_valid, 1);
    @(negedge clk);
    check_eq("bp_next_valid", bus.rsp_valid, 0);
    check_eq("bp_next_ready", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    idle_cycles(3);

    // Reset while the request is in EXEC.
    @(posedge clk); #1;
    valid_v[1] = 1'b1;
    op_v[1]    = 2'b01;
    a_v[1]     = 8'h0F;
    b_v[1]     = 8'hF0;
    @(negedge clk);
    check_eq("rx_ready", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    valid_v[1] = 1'b0;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rx_rsp_valid", bus.rsp_valid, 0);
    check_eq("rx_rsp_data", bus.rsp_data, 0);
    check_eq("rx_rsp_id", bus.rsp_id, 0);
    check_eq("rx_busy", busy, 0);
    check_eq("rx_req_ready", bus.req_ready, 0);
    repeat (4) begin
      @(negedge clk);
      check_eq("rx_no_rsp", bus.rsp_valid, 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) new_req(i);
    @(negedge clk);
    check_eq("rx_ptr0", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    idle_cycles(4);

    // Randomized traffic with random backpressure.
    repeat (3000) drive_step(1'b0, 35, 70);
    idle_cycles(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
